// File: rtl/pipe_mul.sv
`default_nettype none
// ============================================================================
// Module   : pipe_mul
// Purpose  : Fully pipelined XLEN x XLEN integer multiplier covering the
//            RISC-V MUL / MULH / MULHSU / MULHU variants. One request per
//            cycle, fixed latency of STAGES cycles, tag carried alongside,
//            flush of all in-flight work.
// Ports    : clk_i      - clock, rising edge
//            rst_i      - synchronous reset, active low
//            req_i      - request valid
//            flush_i    - kill all in-flight requests (and one arriving now)
//            op_i       - 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//            a_i, b_i   - operands
//            tag_i      - request tag, returned with the result
//            ready_o    - one-cycle pulse per completed request
//            result_o   - selected XLEN half of the product
//            product_o  - full 2*XLEN product
//            tag_o      - tag of the presented result
//            busy_o     - some pipeline stage holds a valid request
// Revision : 1.0 - initial release
// ============================================================================
module pipe_mul #(
    parameter int XLEN   = 32,
    parameter int STAGES = 4,
    parameter int TAG_W  = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_i,
    input  logic                flush_i,
    input  logic [1:0]          op_i,
    input  logic [XLEN-1:0]     a_i,
    input  logic [XLEN-1:0]     b_i,
    input  logic [TAG_W-1:0]    tag_i,
    output logic                ready_o,
    output logic [XLEN-1:0]     result_o,
    output logic [2*XLEN-1:0]   product_o,
    output logic [TAG_W-1:0]    tag_o,
    output logic                busy_o
);

    // The output register is the last of the STAGES registers on the path,
    // so STAGES-1 internal stages precede it.
    localparam int c_NS  = STAGES - 1;
    localparam int c_H   = XLEN / 2;
    // Width of one partial product: (XLEN+1)-bit signed operand times a
    // (c_H+1)-bit signed slice of the other operand.
    localparam int c_PPW = XLEN + c_H + 2;

    localparam logic [1:0] c_OP_MUL   = 2'b00;
    localparam logic [1:0] c_OP_MULHU = 2'b11;

    // ------------------------------------------------------------------------
    // Operand extension and partial products.
    // a is signed for MUL/MULH/MULHSU, b is signed only for MUL/MULH.
    // b is split into an unsigned low half and a signed high half; the two
    // partial products are summed one stage later.
    // ------------------------------------------------------------------------
    logic               w_a_sgn;
    logic               w_b_sgn;
    logic [c_PPW-1:0]   w_a_pp;
    logic [c_PPW-1:0]   w_blo_pp;
    logic [c_PPW-1:0]   w_bhi_pp;
    logic [c_PPW-1:0]   w_pp_lo;
    logic [c_PPW-1:0]   w_pp_hi;
    logic               w_in_vld;

    assign w_a_sgn  = (op_i != c_OP_MULHU) & a_i[XLEN-1];
    assign w_b_sgn  = ~op_i[1] & b_i[XLEN-1];
    assign w_a_pp   = {{(c_PPW-XLEN){w_a_sgn}}, a_i};
    assign w_blo_pp = {{(c_PPW-c_H){1'b0}}, b_i[c_H-1:0]};
    assign w_bhi_pp = {{(c_PPW-(XLEN-c_H)){w_b_sgn}}, b_i[XLEN-1:c_H]};

    // Both operands are pre-extended to the full partial-product width, so a
    // plain modular multiply yields the exact two's-complement result.
    assign w_pp_lo  = w_a_pp * w_blo_pp;
    assign w_pp_hi  = w_a_pp * w_bhi_pp;

    assign w_in_vld = req_i & ~flush_i;

    // Recombine: product = pp_lo + pp_hi * 2^c_H, modulo 2^(2*XLEN).
    function automatic logic [2*XLEN-1:0] f_combine(
        input logic [c_PPW-1:0] lo,
        input logic [c_PPW-1:0] hi
    );
        logic [2*XLEN-1:0] v_lo;
        logic [2*XLEN-1:0] v_hi;
        v_lo = {{(2*XLEN-c_PPW){lo[c_PPW-1]}}, lo};
        v_hi = {{(2*XLEN-c_PPW){hi[c_PPW-1]}}, hi};
        return v_lo + (v_hi << c_H);
    endfunction

    // Signals presented to the output register by whichever stage is last.
    logic                w_last_vld;
    logic [1:0]          w_last_op;
    logic [TAG_W-1:0]    w_last_tag;
    logic [2*XLEN-1:0]   w_last_prod;

    generate
        if (c_NS == 0) begin : g_direct
            // Single-cycle latency: the whole multiply feeds the output reg.
            assign w_last_vld  = w_in_vld;
            assign w_last_op   = op_i;
            assign w_last_tag  = tag_i;
            assign w_last_prod = f_combine(w_pp_lo, w_pp_hi);
            assign busy_o      = 1'b0;
        end else begin : g_pipe
            logic [c_NS:1]       r_vld;
            logic [1:0]          r_op  [1:c_NS];
            logic [TAG_W-1:0]    r_tag [1:c_NS];
            logic [c_PPW-1:0]    r_pp_lo;
            logic [c_PPW-1:0]    r_pp_hi;
            logic [2*XLEN-1:0]   w_sum;

            // Valid bits are the only pipeline state cleared by flush/reset.
            always_ff @(posedge clk_i) begin
                if (!rst_i || flush_i) begin
                    r_vld <= '0;
                end else begin
                    r_vld[1] <= w_in_vld;
                    for (int k = 2; k <= c_NS; k++) begin
                        r_vld[k] <= r_vld[k-1];
                    end
                end
            end

            // Data advances unconditionally; nothing ever stalls.
            always_ff @(posedge clk_i) begin
                r_op[1]  <= op_i;
                r_tag[1] <= tag_i;
                r_pp_lo  <= w_pp_lo;
                r_pp_hi  <= w_pp_hi;
                for (int k = 2; k <= c_NS; k++) begin
                    r_op[k]  <= r_op[k-1];
                    r_tag[k] <= r_tag[k-1];
                end
            end

            assign w_sum = f_combine(r_pp_lo, r_pp_hi);

            if (c_NS == 1) begin : g_sum_last
                assign w_last_prod = w_sum;
            end else begin : g_dly
                // Trailing delay stages; synthesis retiming can pull these
                // back into the multiplier array to balance the tree.
                logic [2*XLEN-1:0] r_prod [2:c_NS];
                always_ff @(posedge clk_i) begin
                    r_prod[2] <= w_sum;
                    for (int k = 3; k <= c_NS; k++) begin
                        r_prod[k] <= r_prod[k-1];
                    end
                end
                assign w_last_prod = r_prod[c_NS];
            end

            assign w_last_vld = r_vld[c_NS];
            assign w_last_op  = r_op[c_NS];
            assign w_last_tag = r_tag[c_NS];
            assign busy_o     = |r_vld;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Output register: loads only for a surviving valid entry, otherwise
    // holds. A flush at the same edge suppresses the load as well.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ready_o   <= 1'b0;
            result_o  <= '0;
            product_o <= '0;
            tag_o     <= '0;
        end else begin
            ready_o <= w_last_vld & ~flush_i;
            if (w_last_vld && !flush_i) begin
                tag_o     <= w_last_tag;
                product_o <= w_last_prod;
                result_o  <= (w_last_op == c_OP_MUL) ? w_last_prod[XLEN-1:0]
                                                     : w_last_prod[2*XLEN-1:XLEN];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_mul.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_mul
// Purpose  : Self-checking bench for pipe_mul. Three instances
//            (XLEN/STAGES = 8/1, 32/4, 64/6) share control inputs; a
//            queue-based arithmetic reference model predicts every output
//            on every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_mul;

    localparam int c_N   = 3;
    localparam int TAG_W = 4;

    typedef struct {
        int unsigned       due;
        logic [TAG_W-1:0]  tag;
        logic [63:0]       res;
        logic [127:0]      prod;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              r_rst_n;
    logic              r_req;
    logic              r_flush;
    logic [1:0]        r_op;
    logic [TAG_W-1:0]  r_tag;
    logic [7:0]        r_a0, r_b0;
    logic [31:0]       r_a1, r_b1;
    logic [63:0]       r_a2, r_b2;

    logic              w_rdy0, w_busy0, w_rdy1, w_busy1, w_rdy2, w_busy2;
    logic [7:0]        w_res0;
    logic [15:0]       w_prod0;
    logic [31:0]       w_res1;
    logic [63:0]       w_prod1;
    logic [63:0]       w_res2;
    logic [127:0]      w_prod2;
    logic [TAG_W-1:0]  w_tag0, w_tag1, w_tag2;

    pipe_mul #(.XLEN(8), .STAGES(1), .TAG_W(TAG_W)) u_dut8 (
        .clk_i(clk), .rst_i(r_rst_n), .req_i(r_req), .flush_i(r_flush),
        .op_i(r_op), .a_i(r_a0), .b_i(r_b0), .tag_i(r_tag),
        .ready_o(w_rdy0), .result_o(w_res0), .product_o(w_prod0),
        .tag_o(w_tag0), .busy_o(w_busy0));

    pipe_mul #(.XLEN(32), .STAGES(4), .TAG_W(TAG_W)) u_dut32 (
        .clk_i(clk), .rst_i(r_rst_n), .req_i(r_req), .flush_i(r_flush),
        .op_i(r_op), .a_i(r_a1), .b_i(r_b1), .tag_i(r_tag),
        .ready_o(w_rdy1), .result_o(w_res1), .product_o(w_prod1),
        .tag_o(w_tag1), .busy_o(w_busy1));

    pipe_mul #(.XLEN(64), .STAGES(6), .TAG_W(TAG_W)) u_dut64 (
        .clk_i(clk), .rst_i(r_rst_n), .req_i(r_req), .flush_i(r_flush),
        .op_i(r_op), .a_i(r_a2), .b_i(r_b2), .tag_i(r_tag),
        .ready_o(w_rdy2), .result_o(w_res2), .product_o(w_prod2),
        .tag_o(w_tag2), .busy_o(w_busy2));

    int unsigned       cyc;
    int unsigned       n_pass;
    int unsigned       n_fail;
    exp_t              q [c_N][$];
    logic [63:0]       last_res  [c_N];
    logic [127:0]      last_prod [c_N];
    logic [TAG_W-1:0]  last_tag  [c_N];

    function automatic int xl(int i);
        case (i)
            0:       return 8;
            1:       return 32;
            default: return 64;
        endcase
    endfunction

    function automatic int st(int i);
        case (i)
            0:       return 1;
            1:       return 4;
            default: return 6;
        endcase
    endfunction

    function automatic logic [63:0] msk(int w);
        logic [63:0] one;
        one = 64'd1;
        return (w >= 64) ? '1 : ((one << w) - 64'd1);
    endfunction

    // Reference: interpret operands as integers per op, multiply exactly.
    function automatic logic [127:0] ref_prod(int w, logic [1:0] op,
                                              logic [63:0] a, logic [63:0] b);
        logic signed [131:0] sa, sb, p, one;
        logic [127:0]        m, one_u;
        one   = 132'sd1;
        one_u = 128'd1;
        sa = $signed({68'd0, a & msk(w)});
        sb = $signed({68'd0, b & msk(w)});
        if (op != 2'b11 && a[w-1]) sa = sa - (one <<< w);
        if (op[1] == 1'b0 && b[w-1]) sb = sb - (one <<< w);
        p = sa * sb;
        m = (w == 64) ? '1 : ((one_u << (2*w)) - one_u);
        return p[127:0] & m;
    endfunction

    function automatic logic [63:0] ref_res(int w, logic [1:0] op, logic [127:0] p);
        logic [127:0] t;
        t = p >> w;
        return ((op == 2'b00) ? p[63:0] : t[63:0]) & msk(w);
    endfunction

    function automatic logic [63:0] opa(int i);
        case (i)
            0:       return {56'd0, r_a0};
            1:       return {32'd0, r_a1};
            default: return r_a2;
        endcase
    endfunction

    function automatic logic [63:0] opb(int i);
        case (i)
            0:       return {56'd0, r_b0};
            1:       return {32'd0, r_b1};
            default: return r_b2;
        endcase
    endfunction

    task automatic chk(string nm, logic [127:0] act, logic [127:0] expv);
        assert (act === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", nm, act, expv);
        end
    endtask

    task automatic get_act(int i, output logic rdy, output logic busy,
                           output logic [63:0] res, output logic [127:0] prod,
                           output logic [TAG_W-1:0] tag);
        case (i)
            0: begin
                rdy = w_rdy0; busy = w_busy0; tag = w_tag0;
                res = {56'd0, w_res0}; prod = {112'd0, w_prod0};
            end
            1: begin
                rdy = w_rdy1; busy = w_busy1; tag = w_tag1;
                res = {32'd0, w_res1}; prod = {64'd0, w_prod1};
            end
            default: begin
                rdy = w_rdy2; busy = w_busy2; tag = w_tag2;
                res = w_res2; prod = w_prod2;
            end
        endcase
    endtask

    task automatic check_inst(int i);
        logic              rdy, busy, exp_rdy;
        logic [63:0]       res;
        logic [127:0]      prod;
        logic [TAG_W-1:0]  tag;
        exp_t              e;
        get_act(i, rdy, busy, res, prod, tag);
        exp_rdy = (q[i].size() > 0) && (q[i][0].due == cyc);
        if (exp_rdy) begin
            e = q[i].pop_front();
            last_res[i]  = e.res;
            last_prod[i] = e.prod;
            last_tag[i]  = e.tag;
        end
        chk($sformatf("x%0d@%0d ready", xl(i), cyc), {127'd0, rdy}, {127'd0, exp_rdy});
        chk($sformatf("x%0d@%0d result", xl(i), cyc), {64'd0, res}, {64'd0, last_res[i]});
        chk($sformatf("x%0d@%0d product", xl(i), cyc), prod, last_prod[i]);
        chk($sformatf("x%0d@%0d tag", xl(i), cyc), {124'd0, tag}, {124'd0, last_tag[i]});
        chk($sformatf("x%0d@%0d busy", xl(i), cyc), {127'd0, busy},
            {127'd0, (q[i].size() > 0)});
    endtask

    // One clock: update the model from the inputs seen at the edge, then
    // compare every instance half a cycle later.
    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < c_N; i++) begin
            if (!r_rst_n) begin
                q[i].delete();
                last_res[i]  = '0;
                last_prod[i] = '0;
                last_tag[i]  = '0;
            end else if (r_flush) begin
                q[i].delete();
            end else if (r_req) begin
                exp_t e;
                e.prod = ref_prod(xl(i), r_op, opa(i), opb(i));
                e.res  = ref_res(xl(i), r_op, e.prod);
                e.tag  = r_tag;
                e.due  = cyc + st(i);
                q[i].push_back(e);
            end
        end
        cyc++;
        @(negedge clk);
        for (int i = 0; i < c_N; i++) check_inst(i);
    endtask

    task automatic set_req(logic [1:0] op, logic [63:0] a, logic [63:0] b,
                           logic [TAG_W-1:0] tag);
        r_req = 1'b1; r_op = op; r_tag = tag;
        r_a0 = a[7:0];  r_b0 = b[7:0];
        r_a1 = a[31:0]; r_b1 = b[31:0];
        r_a2 = a;       r_b2 = b;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Issue one request and run until the 32-bit instance presents it.
    task automatic issue(logic [1:0] op, logic [63:0] a, logic [63:0] b,
                         logic [TAG_W-1:0] tag, bit ext);
        set_req(op, a, b, tag);
        if (ext) begin
            r_a0 = 8'h80;         r_b0 = 8'h80;
            r_a1 = 32'h8000_0000; r_b1 = 32'h8000_0000;
            r_a2 = 64'h8000_0000_0000_0000; r_b2 = 64'h8000_0000_0000_0000;
        end
        tick();
        r_req = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        cyc = 0; n_pass = 0; n_fail = 0;
        for (int i = 0; i < c_N; i++) begin
            last_res[i] = '0; last_prod[i] = '0; last_tag[i] = '0;
        end
        r_rst_n = 1'b0; r_flush = 1'b0;
        set_req(2'($urandom_range(0, 3)), rnd64(), rnd64(), 4'hA);

        // Reset held two edges with a request present.
        tick();
        set_req(2'($urandom_range(0, 3)), rnd64(), rnd64(), 4'h5);
        tick();
        chk("reset result", {96'd0, w_res1}, 128'd0);
        chk("reset product", {64'd0, w_prod1}, 128'd0);
        r_rst_n = 1'b1; r_req = 1'b0;
        repeat (4) tick();

        // Directed ops on the 32-bit, 4-stage instance.
        issue(2'b00, 64'd3, 64'd5, 4'h1, 1'b0);
        chk("MUL 3x5 ready", {127'd0, w_rdy1}, 128'd1);
        chk("MUL 3x5 result", {96'd0, w_res1}, 128'h0000000F);
        issue(2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 4'h2, 1'b0);
        chk("MULHU result", {96'd0, w_res1}, 128'hFFFFFFFE);
        chk("MULHU product", {64'd0, w_prod1}, 128'hFFFFFFFE00000001);
        issue(2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 4'h3, 1'b0);
        chk("MULH result", {96'd0, w_res1}, 128'h0);
        issue(2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 4'h4, 1'b0);
        chk("MULHSU result", {96'd0, w_res1}, 128'hFFFFFFFF);
        chk("MULHSU product", {64'd0, w_prod1}, 128'hFFFFFFFFFFFFFFFE);

        // Signed extremes 0x80..0 x 0x80..0 at every width.
        issue(2'b01, 64'd0, 64'd0, 4'h6, 1'b1);
        chk("MULH ext result", {96'd0, w_res1}, 128'h40000000);
        issue(2'b10, 64'd0, 64'd0, 4'h7, 1'b1);
        chk("MULHSU ext product", {64'd0, w_prod1}, 128'hC000000000000000);
        issue(2'b00, 64'd0, 64'd0, 4'h8, 1'b1);
        issue(2'b11, 64'd0, 64'd0, 4'h9, 1'b1);
        repeat (4) tick();

        // Streaming: 16 back-to-back random requests, tags 0..15.
        for (int t = 0; t < 16; t++) begin
            set_req(2'($urandom_range(0, 3)), rnd64(), rnd64(), 4'(t));
            tick();
        end
        r_req = 1'b0;
        repeat (8) tick();

        // Flush: tags 1..3 in flight, flush together with tag 4, then tag 5.
        for (int t = 1; t <= 3; t++) begin
            set_req(2'($urandom_range(0, 3)), rnd64(), rnd64(), 4'(t));
            tick();
        end
        set_req(2'b00, rnd64(), rnd64(), 4'd4);
        r_flush = 1'b1;
        tick();
        r_flush = 1'b0;
        chk("busy32 after flush", {127'd0, w_busy1}, 128'd0);
        chk("busy64 after flush", {127'd0, w_busy2}, 128'd0);
        set_req(2'b11, rnd64(), rnd64(), 4'd5);
        tick();
        r_req = 1'b0;
        repeat (3) tick();
        chk("tag5 ready", {127'd0, w_rdy1}, 128'd1);
        chk("tag5 tag", {124'd0, w_tag1}, 128'd5);
        repeat (5) tick();

        // Reset mid-stream with three requests in flight.
        for (int t = 10; t < 13; t++) begin
            set_req(2'($urandom_range(0, 3)), rnd64(), rnd64(), 4'(t));
            tick();
        end
        r_req = 1'b0; r_rst_n = 1'b0;
        tick();
        r_rst_n = 1'b1;
        chk("midreset result", {96'd0, w_res1}, 128'd0);
        chk("midreset tag", {124'd0, w_tag1}, 128'd0);
        issue(2'b00, 64'd7, 64'd9, 4'hE, 1'b0);
        chk("after reset ready", {127'd0, w_rdy1}, 128'd1);
        chk("after reset result", {96'd0, w_res1}, 128'd63);
        repeat (4) tick();

        // Random mix with sporadic flushes.
        for (int n = 0; n < 80; n++) begin
            set_req(2'($urandom_range(0, 3)), rnd64(), rnd64(), 4'($urandom_range(0, 15)));
            r_req   = ($urandom_range(0, 3) != 0);
            r_flush = ($urandom_range(0, 15) == 0);
            tick();
        end
        r_req = 1'b0; r_flush = 1'b0;
        repeat (8) tick();

        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end

endmodule
`default_nettype wire
